// File: rtl/im_fetch_queue.sv
// Instruction fetch sequencer with a DEPTH-entry prefetch FIFO tagged by word address.
// Optional FETCH_STATS_EN adds push (fetch_cnt) and flushed-entry (flush_cnt) counters.
module im_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [15:0]              im_addr,
  input  logic [31:0]              im_data,
  input  logic                     fetch_en,
  input  logic                     br_en,
  input  logic [15:0]              br_addr,
  output logic                     ir_valid,
  output logic [31:0]              ir,
  output logic [15:0]              ir_pc,
  input  logic                     ir_ready,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]              fetch_cnt,
  output logic [31:0]              flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   fetch_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [15:0]   pc_mem [DEPTH];
  logic [31:0]   ir_mem [DEPTH];
  logic          push;
  logic          pop;

  assign im_addr  = fetch_pc;
  assign ir_valid = (q_count != '0);
  assign pop      = ir_valid & ir_ready;
  // A full queue may still accept a word when the head leaves on the same edge.
  assign push     = fetch_en & ~br_en & ((q_count < CW'(DEPTH)) | pop);

  assign ir    = ir_valid ? ir_mem[rd_ptr] : '0;
  assign ir_pc = ir_valid ? pc_mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      q_count  <= '0;
    end else if (br_en) begin
      fetch_pc <= br_addr;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      q_count  <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; q_count gates every read, so
  // stale entries are never visible and the array can map to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= fetch_pc;
      ir_mem[wr_ptr] <= im_data;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      // An entry popped on the flush edge was consumed, not discarded.
      if (br_en) begin
        flush_cnt <= flush_cnt + 32'(q_count) - 32'(pop);
      end
    end
  end
`endif

endmodule

// File: tb/tb_im_fetch_queue.sv
// Scoreboard bench for im_fetch_queue: a queue-level model predicts consumed words,
// a negedge monitor compares handshakes and occupancy. Honours FETCH_STATS_EN.
module tb_im_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] im_addr;
  logic [31:0] im_data;
  logic        fetch_en = 1'b0;
  logic        br_en = 1'b0;
  logic [15:0] br_addr = 16'h0000;
  logic        ir_valid;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_ready = 1'b0;
  logic [$clog2(DEPTH):0] q_count;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'h1000_0000 + {16'h0000, a};
  endfunction

  assign im_data = mem_word(im_addr);

  im_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk      (clk),
    .rst      (rst),
    .im_addr  (im_addr),
    .im_data  (im_data),
    .fetch_en (fetch_en),
    .br_en    (br_en),
    .br_addr  (br_addr),
    .ir_valid (ir_valid),
    .ir       (ir),
    .ir_pc    (ir_pc),
    .ir_ready (ir_ready),
    .q_count  (q_count)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt(fetch_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: expected stream of {pc, word} still to be consumed.
  logic [47:0] sb_q[$];
  int          m_cnt   = 0;
  logic [15:0] m_pc    = RESET_PC;
  logic [31:0] m_fetch = 0;
  logic [31:0] m_flush = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cnt = 0; m_pc = RESET_PC; m_fetch = 0; m_flush = 0;
        sb_q.delete();
      end else begin
        automatic bit m_pop  = (m_cnt != 0) && ir_ready;
        automatic bit m_push;
        if (br_en) begin
          m_flush = m_flush + 32'(m_cnt) - 32'(m_pop);
          m_cnt   = 0;
          m_pc    = br_addr;
          sb_q.delete();
        end else begin
          m_push = fetch_en && ((m_cnt < DEPTH) || m_pop);
          m_cnt  = m_cnt + int'(m_push) - int'(m_pop);
          if (m_push) begin
            sb_q.push_back({m_pc, mem_word(m_pc)});
            m_pc    = m_pc + 16'd1;
            m_fetch = m_fetch + 32'd1;
          end
        end
      end
    end
  end

  // Monitor: mid-cycle sampling, pops the scoreboard on every handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("q_count", 64'(q_count), 64'(m_cnt));
        check("ir_valid", 64'(ir_valid), 64'(m_cnt != 0));
        check("im_addr", 64'(im_addr), 64'(m_pc));
        if (m_cnt == 0) begin
          check("empty_ir", 64'(ir), 64'h0);
          check("empty_ir_pc", 64'(ir_pc), 64'h0);
        end
`ifdef FETCH_STATS_EN
        check("fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
        check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
        if (ir_valid && ir_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_pop", 64'(ir_pc), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            automatic logic [47:0] exp = sb_q.pop_front();
            check("head_pc", 64'(ir_pc), 64'(exp[47:32]));
            check("head_ir", 64'(ir), 64'(exp[31:0]));
          end
        end
      end
    end
  end

  task automatic step(input logic fe, input logic rdy, input logic br, input logic [15:0] ba);
    @(posedge clk);
    #1;
    fetch_en = fe; ir_ready = rdy; br_en = br; br_addr = ba;
  endtask

  task automatic run(input int n, input logic fe, input logic rdy);
    for (int i = 0; i < n; i++) step(fe, rdy, 1'b0, 16'h0000);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(ir_valid), 64'h0);
    check("rst_count", 64'(q_count), 64'h0);
    check("rst_addr", 64'(im_addr), 64'(RESET_PC));
    fetch_en = 1'b1; ir_ready = 1'b1;
    rst = 1'b0;

    // Streaming, then saturation with ir_ready low, then drain.
    run(10, 1'b1, 1'b1);
    run(8, 1'b1, 1'b0);
    run(10, 1'b1, 1'b1);

    // Fill a few entries, redirect to 0x0040 while consuming.
    run(3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h0040);
    run(6, 1'b1, 1'b1);

    // Redirect near the top of the address space to exercise PC wrap.
    step(1'b1, 1'b1, 1'b1, 16'hFFFE);
    run(6, 1'b1, 1'b1);

    // Fetch disabled: queue drains, PC holds; then resume.
    run(3, 1'b1, 1'b0);
    run(6, 1'b0, 1'b1);
    run(5, 1'b1, 1'b1);

    // Held redirect over several edges.
    step(1'b1, 1'b0, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 1'b1, 16'h2000);
    step(1'b1, 1'b1, 1'b1, 16'h3000);
    run(6, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      automatic logic        fe  = ($urandom_range(0, 9) < 8);
      automatic logic        rdy = ($urandom_range(0, 9) < 6);
      automatic logic        br  = ($urandom_range(0, 99) < 7);
      automatic logic [15:0] ba  = $urandom_range(0, 1) ? 16'($urandom) :
                                   16'hFFFC + 16'($urandom_range(0, 3));
      step(fe, rdy, br, ba);
    end

    // Build three queued entries, then reset mid-stream.
    step(1'b1, 1'b0, 1'b1, 16'h0100);
    run(3, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    check("pre_rst_count", 64'(q_count), 64'h3);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(ir_valid), 64'h0);
    check("async_rst_count", 64'(q_count), 64'h0);
    check("async_rst_ir", 64'(ir), 64'h0);
    check("async_rst_ir_pc", 64'(ir_pc), 64'h0);
    check("async_rst_addr", 64'(im_addr), 64'(RESET_PC));
`ifdef FETCH_STATS_EN
    check("async_rst_fetch_cnt", 64'(fetch_cnt), 64'h0);
    check("async_rst_flush_cnt", 64'(flush_cnt), 64'h0);
`endif
    ir_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(8, 1'b1, 1'b1);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_fetch_queue.md
Name: im_fetch_queue

Overview:
- Instruction fetch sequencer and prefetch buffer between the instruction memory (16-bit word address, 32-bit combinational read) and the SISC control unit.
- Owns the fetch PC, drives the memory address every cycle and captures returned words into a DEPTH-entry FIFO tagged with their address.
- Consumer pops with a valid/ready handshake; branches redirect the fetch PC and flush prefetched words.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 16'h0000, fetch PC loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- im_addr  output  16  word address to instruction memory (equals fetch_pc).
- im_data  input  32  instruction word returned by memory for im_addr, valid before next rising edge.
- fetch_en  input  1  1 = fetching allowed; 0 = hold fetch_pc, no pushes (queue still drains).
- br_en  input  1  redirect request, sampled at rising edge.
- br_addr  input  16  redirect target word address.
- ir_valid  output  1  head entry present.
- ir  output  32  head instruction word (0 when empty).
- ir_pc  output  16  address of head instruction (0 when empty).
- ir_ready  input  1  consumer accepts head when ir_valid & ir_ready at rising edge.
- q_count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, rd/wr pointers=0, q_count=0, ir_valid=0, ir=0, ir_pc=0; storage need not be cleared.
- im_addr = fetch_pc combinationally at all times.
- pop = ir_valid & ir_ready. push = fetch_en & ~br_en & (q_count<DEPTH | pop).
- Push: at edge, store {fetch_pc, im_data} at wr_ptr; wr_ptr++; fetch_pc = fetch_pc+1, wrapping 16'hFFFF -> 16'h0000.
- Pop: rd_ptr++ at edge; pointers wrap modulo DEPTH.
- q_count += push - pop; push and pop same cycle when full is legal (count stays DEPTH).
- ir/ir_pc driven from head entry; ir_valid = (q_count!=0). Outputs stable while ir_valid & ~ir_ready.
- Latency: word at address A pushed at edge N is at head earliest after edge N (empty queue) -> ir_valid high in cycle N+1.
- Redirect (br_en=1 at edge): highest priority. Queue flushed (pointers=0, q_count=0), no push that edge, fetch_pc=br_addr. Concurrent pop is discarded with flush. First word from br_addr visible after the following edge (2 edges after br_en sampled), provided fetch_en=1.
- br_en held multiple cycles: re-flushes each edge; fetching resumes the edge after deassertion.
- fetch_en=0: fetch_pc and queue contents unchanged except by pop/redirect; redirect still loads fetch_pc.
- Empty: ir_ready ignored, no pointer movement. Full without pop: no push, fetch_pc held.
- Reset mid-operation: all state returns to reset values immediately; first fetch of RESET_PC on first edge after rst deasserts.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined: adds outputs fetch_cnt[31:0] (pushes) and flush_cnt[31:0] (valid entries discarded by redirect, i.e. q_count at flush edge, minus 1 if pop same edge); both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, memory words 0..7 = 32'h1000_0000+addr, fetch_en=1, ir_ready=1 -> ir_valid from cycle 2, ir_pc 0,1,2,... one per cycle, ir matches.
- ir_ready=0, DEPTH=4 -> q_count saturates at 4, im_addr holds 16'h0004; raise ir_ready -> pops 0..3 then 4 with no gap or duplicate.
- Queue holding 0..2, pulse br_en with br_addr=16'h0040 while ir_ready=1 -> q_count=0 next cycle, ir_valid low one cycle, next head ir_pc=16'h0040.
- br_en=1 with br_addr=16'hFFFE -> heads 16'hFFFE, 16'hFFFF, 16'h0000 in order.
- fetch_en=0 with 3 queued, ir_ready=1 -> drains 3, ir_valid=0, im_addr constant; fetch_en=1 resumes at next address.
- Assert rst mid-stream with q_count=3 -> ir_valid, q_count, ir, ir_pc read 0 immediately; after release fetch resumes at RESET_PC; with FETCH_STATS_EN, counters read 0.
